fwd_hazard_tracker: RTL and testbench

Parametrised successor to the current forwarding unit. It holds its own shift-register record of in-flight register writes across D post-EX stages and uses it to generate priority-encoded forwarding selects for the EX-stage ALU operands and the ID-stage branch comparator. It also detects load-use and branch hazards, raising a same-cycle stall. It sits beside the hazard unit between ID/EX and the later pipeline registers, and adds a saturating stall counter and a sticky hazard-error flag.

---
 rtl/fwd_hazard_tracker.sv | 118 +++++++++++
 tb/tb_fwd_hazard_tracker.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_tracker.sv
// Forwarding-select and hazard-stall generator. Keeps its own shift-register record of
// in-flight register writes across FWD_DEPTH post-EX stages.
module fwd_hazard_tracker #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned FWD_DEPTH = 2,
  parameter int unsigned SEL_W     = $clog2(FWD_DEPTH + 1),
  parameter int unsigned BR_IN_ID  = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ex_valid,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic [ADDR_W-1:0] ex_rs,
  input  logic [ADDR_W-1:0] ex_rt,
  input  logic              id_valid,
  input  logic              id_branch,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  output logic [SEL_W-1:0]  fwd_a,
  output logic [SEL_W-1:0]  fwd_b,
  output logic [SEL_W-1:0]  br_fwd_a,
  output logic [SEL_W-1:0]  br_fwd_b,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic              hazard_err
);

  // Index 0 is S1 (EX/MEM), index FWD_DEPTH-1 is the last stage before regfile write.
  logic [FWD_DEPTH-1:0]             v_q;
  logic [FWD_DEPTH-1:0]             ld_q;
  logic [FWD_DEPTH-1:0][ADDR_W-1:0] rd_q;
  logic [CNT_W-1:0]                 stall_cnt_q;
  logic                             hazard_err_q;

  logic ex_wr, id_hit_ex, l_haz, b_haz, s1_ld_id_hit, s1_ld_ex_hit;

  // Youngest (smallest k) match wins; 0 means use the pipeline-register value.
  function automatic logic [SEL_W-1:0] match_sel(
    input logic [FWD_DEPTH-1:0]             v,
    input logic [FWD_DEPTH-1:0][ADDR_W-1:0] rd,
    input logic [ADDR_W-1:0]                src
  );
    logic [SEL_W-1:0] sel;
    logic             found;
    sel   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < FWD_DEPTH; k++) begin
      if (!found && v[k] && (rd[k] == src)) begin
        sel   = SEL_W'(k + 1);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v_q  <= '0;
      ld_q <= '0;
      rd_q <= '0;
    end else begin
      v_q  <= {v_q[FWD_DEPTH-2:0], ex_wr};
      ld_q <= {ld_q[FWD_DEPTH-2:0], ex_mem_read};
      rd_q <= {rd_q[FWD_DEPTH-2:0], ex_rd};
    end
  end

  always_comb begin
    ex_wr        = ex_valid & ex_reg_write & (ex_rd != '0);
    id_hit_ex    = (ex_rd == id_rs) | (ex_rd == id_rt);
    l_haz        = ex_wr & ex_mem_read & id_hit_ex;
    s1_ld_id_hit = v_q[0] & ld_q[0] & ((rd_q[0] == id_rs) | (rd_q[0] == id_rt));
    s1_ld_ex_hit = v_q[0] & ld_q[0] & ((rd_q[0] == ex_rs) | (rd_q[0] == ex_rt));
    fwd_a        = match_sel(v_q, rd_q, ex_rs);
    fwd_b        = match_sel(v_q, rd_q, ex_rt);
  end

  if (BR_IN_ID != 0) begin : g_br
    logic             br_en;
    logic [SEL_W-1:0] sel_a, sel_b;
    always_comb begin
      br_en = id_valid & id_branch;
      sel_a = match_sel(v_q, rd_q, id_rs);
      sel_b = match_sel(v_q, rd_q, id_rt);
      // A load still in S1 has no data yet; the stall covers it.
      br_fwd_a = (br_en && !((sel_a == SEL_W'(1)) && ld_q[0])) ? sel_a : '0;
      br_fwd_b = (br_en && !((sel_b == SEL_W'(1)) && ld_q[0])) ? sel_b : '0;
      b_haz    = id_branch & ((ex_wr & id_hit_ex) | s1_ld_id_hit);
    end
  end else begin : g_no_br
    assign br_fwd_a = '0;
    assign br_fwd_b = '0;
    assign b_haz    = 1'b0;
  end

  assign stall = id_valid & (l_haz | b_haz);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q  <= '0;
      hazard_err_q <= 1'b0;
    end else begin
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (s1_ld_ex_hit) begin
        hazard_err_q <= 1'b1;
      end
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign hazard_err = hazard_err_q;

endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// Bench for fwd_hazard_tracker: default instance plus a depth-3, no-branch, 2-bit-counter
// instance, both checked every cycle against a list-based model and pinned by directed cases.
module tb_fwd_hazard_tracker;
  logic       clk = 1'b0;
  logic       rstn;
  logic       ex_valid, ex_reg_write, ex_mem_read, id_valid, id_branch;
  logic [4:0] ex_rd, ex_rs, ex_rt, id_rs, id_rt;
  logic [1:0] fa0, fb0, ba0, bb0, fa1, fb1, ba1, bb1, cnt1;
  logic [15:0] cnt0;
  logic       st0, st1, he0, he1;

  int ncheck = 0;
  int nfail  = 0;

  // Model: entry k describes the write k stages past EX (k=1 youngest).
  int mv[1:3], mrd[1:3], mld[1:3];
  int mcnt0, mcnt1, mherr;

  fwd_hazard_tracker dut0 (
    .clk(clk), .rstn(rstn), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .id_valid(id_valid), .id_branch(id_branch), .id_rs(id_rs), .id_rt(id_rt),
    .fwd_a(fa0), .fwd_b(fb0), .br_fwd_a(ba0), .br_fwd_b(bb0), .stall(st0),
    .stall_cnt(cnt0), .hazard_err(he0)
  );

  fwd_hazard_tracker #(.FWD_DEPTH(3), .BR_IN_ID(0), .CNT_W(2)) dut1 (
    .clk(clk), .rstn(rstn), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .id_valid(id_valid), .id_branch(id_branch), .id_rs(id_rs), .id_rt(id_rt),
    .fwd_a(fa1), .fwd_b(fb1), .br_fwd_a(ba1), .br_fwd_b(bb1), .stall(st1),
    .stall_cnt(cnt1), .hazard_err(he1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    ncheck++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_fwd(input int x, input int depth);
    for (int k = 1; k <= depth; k++) if (mv[k] != 0 && mrd[k] == x) return k;
    return 0;
  endfunction

  function automatic int m_br(input int x, input int depth, input int brin);
    int k;
    if (brin == 0 || !(id_valid && id_branch)) return 0;
    k = m_fwd(x, depth);
    if (k == 1 && mld[1] != 0) return 0;
    return k;
  endfunction

  function automatic int m_stall(input int brin);
    bit wr, hit, l, b;
    wr  = ex_valid && ex_reg_write && ex_rd != 0;
    hit = (ex_rd == id_rs) || (ex_rd == id_rt);
    l   = wr && ex_mem_read && hit;
    b   = (brin != 0) && id_branch &&
          ((wr && hit) || (mv[1] != 0 && mld[1] != 0 && (mrd[1] == id_rs || mrd[1] == id_rt)));
    return int'(id_valid && (l || b));
  endfunction

  // Per-cycle compare against the model, then advance the model for the coming edge.
  always @(negedge clk) begin
    int s0, s1;
    if (!rstn) begin
      for (int k = 1; k <= 3; k++) begin mv[k] = 0; mrd[k] = 0; mld[k] = 0; end
      mcnt0 = 0; mcnt1 = 0; mherr = 0;
    end
    s0 = m_stall(1);
    s1 = m_stall(0);
    chk("d0.fwd_a", fa0, m_fwd(ex_rs, 2));
    chk("d0.fwd_b", fb0, m_fwd(ex_rt, 2));
    chk("d0.br_fwd_a", ba0, m_br(id_rs, 2, 1));
    chk("d0.br_fwd_b", bb0, m_br(id_rt, 2, 1));
    chk("d0.stall", st0, s0);
    chk("d0.stall_cnt", cnt0, mcnt0);
    chk("d0.hazard_err", he0, mherr);
    chk("d1.fwd_a", fa1, m_fwd(ex_rs, 3));
    chk("d1.fwd_b", fb1, m_fwd(ex_rt, 3));
    chk("d1.br_fwd_a", ba1, m_br(id_rs, 3, 0));
    chk("d1.br_fwd_b", bb1, m_br(id_rt, 3, 0));
    chk("d1.stall", st1, s1);
    chk("d1.stall_cnt", cnt1, mcnt1);
    chk("d1.hazard_err", he1, mherr);
    if (rstn) begin
      if (mv[1] != 0 && mld[1] != 0 && (mrd[1] == ex_rs || mrd[1] == ex_rt)) mherr = 1;
      if (s0 != 0 && mcnt0 < 65535) mcnt0++;
      if (s1 != 0 && mcnt1 < 3) mcnt1++;
      for (int k = 3; k >= 2; k--) begin
        mv[k] = mv[k-1]; mrd[k] = mrd[k-1]; mld[k] = mld[k-1];
      end
      mv[1]  = int'(ex_valid && ex_reg_write && ex_rd != 0);
      mrd[1] = ex_rd;
      mld[1] = ex_mem_read;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input bit v, input bit rw, input bit mr, input int rd, input int rs,
                        input int rt);
    ex_valid = v; ex_reg_write = rw; ex_mem_read = mr;
    ex_rd = 5'(rd); ex_rs = 5'(rs); ex_rt = 5'(rt);
  endtask

  task automatic set_id(input bit v, input bit br, input int rs, input int rt);
    id_valid = v; id_branch = br; id_rs = 5'(rs); id_rt = 5'(rt);
  endtask

  task automatic idle();
    set_ex(0, 0, 0, 0, 0, 0);
    set_id(0, 0, 0, 0);
  endtask

  initial begin
    rstn = 1'b0;
    idle();
    cyc(); cyc();
    #1;
    chk("rst.fwd_a", fa0, 0);
    chk("rst.br_fwd_b", bb0, 0);
    chk("rst.stall", st0, 0);
    chk("rst.stall_cnt", cnt0, 0);
    chk("rst.hazard_err", he0, 0);
    rstn = 1'b1;

    // add $3 then consumer, bubble, consumer
    cyc(); set_ex(1, 1, 0, 3, 1, 2); set_id(0, 0, 0, 0);
    cyc(); set_ex(1, 0, 0, 0, 3, 0); #1;
    chk("alu.fwd_a_s1", fa0, 1);
    chk("alu.d1_fwd_a_s1", fa1, 1);
    cyc(); set_ex(0, 0, 0, 0, 3, 0); #1;
    chk("alu.fwd_a_s2", fa0, 2);
    cyc(); set_ex(1, 1, 0, 0, 1, 2);
    cyc(); set_ex(1, 0, 0, 0, 0, 0); #1;
    chk("alu.rd0_fwd_a", fa0, 0);
    cyc(); idle();
    cyc();
    cyc();

    // back-to-back writers of $5: youngest wins
    cyc(); set_ex(1, 1, 0, 5, 1, 2);
    cyc(); set_ex(1, 1, 0, 5, 1, 2);
    cyc(); set_ex(1, 0, 0, 0, 0, 5); #1;
    chk("young.fwd_b", fb0, 1);
    chk("young.d1_fwd_b", fb1, 1);
    cyc(); idle();
    cyc(); cyc(); cyc();

    // lw $4 -> ALU user
    cyc(); set_ex(1, 1, 1, 4, 0, 0); set_id(1, 0, 4, 0); #1;
    chk("ldu.stall", st0, 1);
    cyc(); set_ex(0, 0, 0, 0, 0, 0); #1;
    chk("ldu.stall_off", st0, 0);
    chk("ldu.stall_cnt", cnt0, 1);
    cyc(); set_ex(1, 0, 0, 0, 4, 0); set_id(0, 0, 0, 0); #1;
    chk("ldu.fwd_a", fa0, 2);
    cyc(); idle();
    cyc(); cyc(); cyc();

    // lw $6 -> beq: two stalls with branches in ID, one without
    cyc(); set_ex(1, 1, 1, 6, 0, 0); set_id(1, 1, 0, 6); #1;
    chk("ldb.stall1", st0, 1);
    chk("ldb.d1_stall1", st1, 1);
    cyc(); set_ex(0, 0, 0, 0, 0, 0); #1;
    chk("ldb.stall2", st0, 1);
    chk("ldb.d1_stall2", st1, 0);
    chk("ldb.br_fwd_b_s1", bb0, 0);
    cyc(); #1;
    chk("ldb.stall3", st0, 0);
    chk("ldb.br_fwd_b", bb0, 2);
    chk("ldb.d1_br_fwd_b", bb1, 0);
    chk("ldb.stall_cnt", cnt0, 3);
    chk("ldb.d1_stall_cnt", cnt1, 2);
    cyc(); idle();
    cyc(); cyc(); cyc();

    // load in S1 read by EX with no bubble: sticky error; then saturate 2-bit counter
    cyc(); set_ex(1, 1, 1, 7, 0, 0);
    cyc(); set_ex(1, 0, 0, 0, 7, 0); #1;
    chk("herr.fwd_a", fa0, 1);
    chk("herr.before", he0, 0);
    cyc(); idle(); #1;
    chk("herr.set", he0, 1);
    cyc(); set_ex(1, 1, 1, 8, 0, 0); set_id(1, 0, 8, 0);
    cyc();
    cyc(); idle(); #1;
    chk("sat.stall_cnt", cnt0, 5);
    chk("sat.d1_stall_cnt", cnt1, 3);
    chk("herr.held", he0, 1);

    // reset during a branch stall sourced from the tracker
    cyc(); set_ex(1, 1, 1, 9, 0, 0);
    cyc(); set_ex(0, 0, 0, 0, 0, 0); set_id(1, 1, 9, 0); #1;
    chk("rstmid.stall_before", st0, 1);
    rstn = 1'b0; #1;
    chk("rstmid.stall_after", st0, 0);
    chk("rstmid.hazard_err", he0, 0);
    chk("rstmid.stall_cnt", cnt0, 0);
    cyc(); idle();
    cyc(); rstn = 1'b1;

    // randomized traffic, compared by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      cyc();
      rstn = ($urandom_range(0, 199) != 0);
      set_ex($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      set_id($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 0,
             $urandom_range(0, 7), $urandom_range(0, 7));
    end
    cyc();
    rstn = 1'b1;
    idle();
    cyc(); cyc();
    #2;
    $display("%0d/%0d checks passed", ncheck - nfail, ncheck);
    $finish;
  end
endmodule
